pc_unit_ras: RTL
================

Name: pc_unit_ras

Overview:
Parametrised next-generation program counter for the single-cycle RV32 core. It selects the next PC from four sources: sequential, PC-relative branch, register-indirect jump, and return-address-stack pop. It adds a trap redirect, target-misalignment detection and a circular return-address stack (RAS). It sits at the front of the fetch path and drives the instruction-memory address.

Parameters:
WIDTH, 32, PC / immediate / register width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC value on Trap or misaligned target
RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-low reset
LOAD  input  1  PC update enable; 0 = hold PC (stall)
Trap  input  1  redirect to TRAP_VEC; overrides LOAD and PCSrc
PCSrc  input  2  00 seq PC+4, 01 branch PC+ImmExt, 10 jalr (Rs1+ImmExt)&~1, 11 RAS pop
ImmExt  input  WIDTH  sign-extended immediate
Rs1  input  WIDTH  jalr base register value
Call  input  1  push PC+4 onto RAS when the update is accepted
PC  output  WIDTH  current PC (register)
PCPlus4  output  WIDTH  PC+4 (combinational, link value)
MisalignErr  output  1  one-cycle pulse, registered: last redirect was misaligned
RasEmpty  output  1  RAS count == 0 (combinational from state)
RasFull  output  1  RAS count == RAS_DEPTH
RasOvf  output  1  sticky: a push overwrote the oldest entry
RasUnf  output  1  sticky: a pop was attempted on an empty stack

Behaviour:
- Reset: RST==0 at a posedge sets PC=RESET_VEC, RAS pointer=0, count=0, MisalignErr=0, RasOvf=0, RasUnf=0. RAS entry contents are don't-care. Reset wins over every other input.
- Priority per edge: reset > Trap > LOAD==0 (hold) > PCSrc.
- Trap=1: PC<=TRAP_VEC; RAS unchanged; MisalignErr<=0.
- LOAD=0, no Trap: PC and RAS hold; MisalignErr<=0; sticky flags hold.
- Target computation: all adds are modulo 2^WIDTH (wrap, no flag). jalr clears bit 0 before the alignment check.
- Misaligned: target[1:0]!=0 (IALIGN=32). Then PC<=TRAP_VEC, MisalignErr<=1 for exactly one cycle, no RAS push/pop. Sequential targets are never misaligned if PC is aligned.
- PCSrc=11 with RAS empty: PC<=PC+4, RasUnf<=1, count stays 0, and a Call push in the same cycle still proceeds.
- PCSrc=11 with RAS non-empty: PC<=top entry, pointer decrements, count decrements.
- Call=1 and update accepted (LOAD=1, no Trap, not misaligned): PC+4 (the old PC) is pushed.
  - If not full: count increments.
  - If full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, RasOvf<=1.
- Pop and push in the same cycle on a non-empty RAS: the popped top is the target, PC+4 replaces that same slot, count unchanged.
- Latency: the new PC is visible one cycle after the accepting edge. Sticky flags clear only on reset.

Test Plan:
- Reset/seq: RST=0 for 1 edge, then RST=1, LOAD=1, PCSrc=00 for 4 edges -> PC 0,4,8,12,16; all flags 0.
- Branch + misalign: PC=8, PCSrc=01, ImmExt=6 -> PC=0x100, MisalignErr=1 for one cycle only. Then ImmExt=-8 from 0x100 -> PC=0xF8.
- Stall/trap: LOAD=0 for 3 edges -> PC held. Trap=1 with LOAD=0 -> PC=0x100.
- jalr: Rs1=0x203, ImmExt=1, PCSrc=10 -> PC=0x204 (bit0 cleared, aligned). Rs1=0x201, ImmExt=1 -> 0x202 misaligned -> PC=0x100, MisalignErr=1.
- RAS fill/overflow: 5 calls at PCs 0x10,0x20,0x30,0x40,0x50 (branch targets) -> RasFull=1, RasOvf=1. Then 4 pops -> PC=0x54,0x44,0x34,0x24, RasEmpty=1. A 5th pop -> PC=prev+4, RasUnf=1.
- Push+pop same cycle: stack top=0x44, PC=0x80, Call=1, PCSrc=11 -> PC=0x44, top now 0x84, count unchanged. Reset mid-sequence -> PC=0, count 0, flags cleared.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Next-PC generator for the single-cycle RV32 core. Selects between
// sequential, branch, jalr and return-address-stack targets, redirects
// traps and misaligned targets to TRAP_VEC, and maintains a circular
// return-address stack with overflow/underflow sticky flags.
module pc_unit_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic             Trap,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] ImmExt,
  input  logic [WIDTH-1:0] Rs1,
  input  logic             Call,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             MisalignErr,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasOvf,
  output logic             RasUnf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // ptr_q is the next free slot; the top of stack lives at ptr_q-1.
  // Because the depth is a power of two the pointer wraps naturally, so a
  // push on a full stack lands on the oldest entry.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] target;
  logic             misalign;
  logic             pop_req;
  logic             accept;
  logic             do_push;
  logic             do_pop;
  logic             do_unf;

  assign PCPlus4  = PC + WIDTH'(4);
  assign RasEmpty = (cnt_q == '0);
  assign RasFull  = (cnt_q == CW'(RAS_DEPTH));
  assign top_idx  = ptr_q - PW'(1);
  assign pop_req  = (PCSrc == 2'b11);

  // Target selection; an empty-stack pop falls through to PC+4.
  always_comb begin
    target = PCPlus4;
    case (PCSrc)
      2'b00: target = PCPlus4;
      2'b01: target = PC + ImmExt;
      2'b10: target = (Rs1 + ImmExt) & ~WIDTH'(1);
      2'b11: target = RasEmpty ? PCPlus4 : ras_mem[top_idx];
      default: target = PCPlus4;
    endcase
  end

  assign misalign = (target[1:0] != 2'b00);
  assign accept   = RST && LOAD && !Trap && !misalign;
  assign do_push  = accept && Call;
  assign do_pop   = accept && pop_req && !RasEmpty;
  assign do_unf   = accept && pop_req && RasEmpty;
  // A simultaneous pop and push rewrites the slot just popped.
  assign wr_idx   = do_pop ? top_idx : ptr_q;

  // PC, stack pointer/count and status flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      PC          <= RESET_VEC;
      ptr_q       <= '0;
      cnt_q       <= '0;
      MisalignErr <= 1'b0;
      RasOvf      <= 1'b0;
      RasUnf      <= 1'b0;
    end else if (Trap) begin
      PC          <= TRAP_VEC;
      MisalignErr <= 1'b0;
    end else if (!LOAD) begin
      MisalignErr <= 1'b0;
    end else if (misalign) begin
      PC          <= TRAP_VEC;
      MisalignErr <= 1'b1;
    end else begin
      PC          <= target;
      MisalignErr <= 1'b0;
      if (do_unf) RasUnf <= 1'b1;
      if (do_push && !do_pop) begin
        ptr_q <= ptr_q + PW'(1);
        if (RasFull) RasOvf <= 1'b1;
        else         cnt_q  <= cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Stack storage has no reset; entries are only read when counted valid.
  always_ff @(posedge CLK) begin
    if (do_push) ras_mem[wr_idx] <= PCPlus4;
  end

endmodule
